modmul_interleaved: RTL and testbench



---
 rtl/modmul_pkg.sv | 25 ++
 rtl/modmul_interleaved_if.sv | 47 ++++
 rtl/modmul_step.sv | 35 +++
 rtl/modmul_interleaved.sv | 133 +++++++++++++
 tb/tb_modmul_interleaved.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/modmul_pkg.sv
// Shared types and width helpers for the interleaved modular multiplier.
// Latency: none, declarations only.
// Backpressure: not applicable.
package modmul_pkg;

    // Controller states. The 2-bit encoding leaves one spare code.
    // The top recovers from that code to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the bit-index counter that walks X from MSB to LSB.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    // Width of the accumulator and the intermediate sums.
    // 2R + Y < 3M, so two guard bits keep every intermediate sum exact.
    function automatic int acc_width(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/modmul_interleaved_if.sv
// Operand/result handshake bundle for modmul_interleaved.
// Latency: none, wiring only.
// Backpressure: in_ready gates operands; out_ready holds Q until consumed.
// The MODMUL_RANGE_CHECK_EN macro adds the err flag alongside Q.
interface modmul_interleaved_if #(
    parameter int WIDTH = 256
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic [WIDTH-1:0] M;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Q;
`ifdef MODMUL_RANGE_CHECK_EN
    logic             err;
`endif

`ifdef MODMUL_RANGE_CHECK_EN
    // The operand scheduler and the result consumer drive this side.
    modport master (
        output in_valid, X, Y, M, out_ready,
        input  in_ready, out_valid, Q, err
    );

    // The multiplier drives this side.
    modport slave (
        input  in_valid, X, Y, M, out_ready,
        output in_ready, out_valid, Q, err
    );
`else
    // The operand scheduler and the result consumer drive this side.
    modport master (
        output in_valid, X, Y, M, out_ready,
        input  in_ready, out_valid, Q
    );

    // The multiplier drives this side.
    modport slave (
        input  in_valid, X, Y, M, out_ready,
        output in_ready, out_valid, Q
    );
`endif

endinterface

// File: rtl/modmul_step.sv
// One radix-2 interleaved iteration: R' = 2R + (bit ? Y : 0), reduced below M.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register o_r.
module modmul_step
    import modmul_pkg::*;
#(
    parameter  int WIDTH = 256,
    localparam int AW    = acc_width(WIDTH)
) (
    input  logic [AW-1:0]    i_r,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_y,
    input  logic [WIDTH-1:0] i_m,
    output logic [AW-1:0]    o_r
);

    logic [AW-1:0] w_mod;
    logic [AW-1:0] w_dbl;
    logic [AW-1:0] w_add;
    logic [AW-1:0] w_sub1;

    assign w_mod = {2'b00, i_m};

    // Shift in the next multiplicand bit position.
    // If R < M, then 2R < 2M and the MSB shifted out is always zero.
    assign w_dbl = i_r << 1;

    // Add Y only when the scanned bit of X is set.
    assign w_add = w_dbl + (i_bit ? {2'b00, i_y} : '0);

    // w_add < 3M, so at most two subtractions bring it back below M.
    assign w_sub1 = (w_add >= w_mod) ? (w_add - w_mod) : w_add;
    assign o_r    = (w_sub1 >= w_mod) ? (w_sub1 - w_mod) : w_sub1;

endmodule

// File: rtl/modmul_interleaved.sv
// Iterative radix-2 (Blakley) modular multiplier: Q = (X * Y) mod M, with M supplied at runtime.
// Latency: out_valid rises WIDTH cycles after the accept edge; back-to-back, one result per WIDTH+1 cycles.
// Backpressure: the result is held in DONE until out_ready; new operands may be taken on that same edge.
// Optional MODMUL_RANGE_CHECK_EN: flags X>=M, Y>=M or M==0 on bus.err and forces Q to zero.
module modmul_interleaved
    import modmul_pkg::*;
#(
    parameter  int WIDTH = 256,
    localparam int CNT_W = cnt_width(WIDTH),
    localparam int AW    = acc_width(WIDTH)
) (
    input  logic                clock,
    input  logic                reset,
    modmul_interleaved_if.slave bus
);

    state_t           r_state;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_q;
    logic [AW-1:0]    r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_vld;

    logic             w_in_rdy;
    logic             w_accept;
    logic             w_bit;
    logic             w_last;
    logic [AW-1:0]    w_acc_next;

`ifdef MODMUL_RANGE_CHECK_EN
    logic             r_flag;
    logic             r_err;
    logic             w_flag;

    // A range violation is judged on the operands as presented, not on the latched copies.
    assign w_flag = (bus.X >= bus.M) | (bus.Y >= bus.M) | (bus.M == '0);
`endif

    // The block is free when idle, or when the held result leaves on this edge.
    assign w_in_rdy = (r_state == IDLE) | ((r_state == DONE) & bus.out_ready);
    assign w_accept = bus.in_valid & w_in_rdy;

    // X is scanned MSB first. r_cnt names the bit consumed by this cycle's step.
    assign w_bit  = r_x[r_cnt];
    assign w_last = (r_cnt == '0);

    modmul_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_r   (r_acc),
        .i_bit (w_bit),
        .i_y   (r_y),
        .i_m   (r_m),
        .o_r   (w_acc_next)
    );

    // Controller: operand capture, one iteration per CALC cycle, result hand-off.
    // An accept in DONE re-enters CALC directly, which gives the WIDTH+1 back-to-back cadence.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_x       <= '0;
            r_y       <= '0;
            r_m       <= '0;
            r_q       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_out_vld <= 1'b0;
`ifdef MODMUL_RANGE_CHECK_EN
            r_flag    <= 1'b0;
            r_err     <= 1'b0;
`endif
        end else if (w_accept) begin
            r_x       <= bus.X;
            r_y       <= bus.Y;
            r_m       <= bus.M;
            r_acc     <= '0;
            r_cnt     <= CNT_W'(WIDTH - 1);
            r_out_vld <= 1'b0;
            r_state   <= CALC;
`ifdef MODMUL_RANGE_CHECK_EN
            r_flag    <= w_flag;
            r_err     <= 1'b0;
`endif
        end else begin
            case (r_state)
                CALC: begin
                    r_acc <= w_acc_next;
                    if (w_last) begin
                        r_q       <= w_acc_next[WIDTH-1:0];
                        r_out_vld <= 1'b1;
                        r_state   <= DONE;
`ifdef MODMUL_RANGE_CHECK_EN
                        // The loop still runs its full length, so latency does not depend on the flag.
                        if (r_flag) begin
                            r_q   <= '0;
                            r_err <= 1'b1;
                        end
`endif
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    // Q keeps its last value after the handshake; only out_valid drops.
                    if (bus.out_ready) begin
                        r_out_vld <= 1'b0;
                        r_state   <= IDLE;
`ifdef MODMUL_RANGE_CHECK_EN
                        r_err     <= 1'b0;
`endif
                    end
                end
                IDLE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_rdy;
    assign bus.out_valid = r_out_vld;
    assign bus.Q         = r_q;
`ifdef MODMUL_RANGE_CHECK_EN
    assign bus.err       = r_err;
`endif

endmodule

// File: tb/tb_modmul_interleaved.sv
// Self-checking bench for modmul_interleaved at WIDTH = 8, 16 and 256.
// Table-driven vectors and hand-written corner sequences push expected results into per-instance queues.
// Negedge monitors pop those queues and compare on each output handshake.
module tb_modmul_interleaved;

    logic clock;
    logic reset;

    int total = 0;
    int bad   = 0;

    modmul_interleaved_if #(.WIDTH(8))   b8   ();
    modmul_interleaved_if #(.WIDTH(16))  b16  ();
    modmul_interleaved_if #(.WIDTH(256)) b256 ();

    modmul_interleaved #(.WIDTH(8))   u8   (.clock(clock), .reset(reset), .bus(b8));
    modmul_interleaved #(.WIDTH(16))  u16  (.clock(clock), .reset(reset), .bus(b16));
    modmul_interleaved #(.WIDTH(256)) u256 (.clock(clock), .reset(reset), .bus(b256));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [7:0]   q8   [$];
    logic [15:0]  q16  [$];
    logic [255:0] q256 [$];
    logic [7:0]   e8;
    logic [15:0]  e16;
    logic [255:0] e256;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] m;
        logic [7:0] q;
    } vec8_t;

    vec8_t tbl [8];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference model: a full-width product followed by a true modulo, independent of the bit-serial algorithm.
    function automatic logic [255:0] ref_mod(input logic [255:0] x, input logic [255:0] y, input logic [255:0] m);
        logic [511:0] p;
        p = {256'b0, x} * {256'b0, y};
        p = p % {256'b0, m};
        return p[255:0];
    endfunction

    // Scoreboard monitors: a handshake happens on the next rising edge whenever valid and ready are high at the negedge.
    always @(negedge clock) begin
        if (!reset && b8.out_valid && b8.out_ready) begin
            if (q8.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_out8: got Q=%0h, want no output", b8.Q);
            end else begin
                e8 = q8.pop_front();
                check("q8", {248'b0, b8.Q}, {248'b0, e8});
            end
        end
    end

    always @(negedge clock) begin
        if (!reset && b16.out_valid && b16.out_ready) begin
            if (q16.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_out16: got Q=%0h, want no output", b16.Q);
            end else begin
                e16 = q16.pop_front();
                check("q16", {240'b0, b16.Q}, {240'b0, e16});
            end
        end
    end

    always @(negedge clock) begin
        if (!reset && b256.out_valid && b256.out_ready) begin
            if (q256.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_out256: got Q=%0h, want no output", b256.Q);
            end else begin
                e256 = q256.pop_front();
                check("q256", b256.Q, e256);
            end
        end
    end

    // One complete 8-bit operation from an idle block, with out_ready held high.
    task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic [7:0] m, input logic [7:0] q);
        int n;
        b8.X = x; b8.Y = y; b8.M = m; b8.in_valid = 1'b1;
        check("accept_rdy8", b8.in_ready, 1);
        q8.push_back(q);
        @(posedge clock); #1;
        b8.in_valid = 1'b0;
        n = 0;
        while (!b8.out_valid && n < 40) begin @(posedge clock); #1; n++; end
        check("latency8", n, 8);
        check("done_rdy8", b8.in_ready, 1);
        @(posedge clock); #1;
    endtask

    // One complete 256-bit operation, with the expected result taken from the reference model.
    task automatic run256(input logic [255:0] x, input logic [255:0] y, input logic [255:0] m);
        int n;
        b256.X = x; b256.Y = y; b256.M = m; b256.in_valid = 1'b1;
        check("accept_rdy256", b256.in_ready, 1);
        q256.push_back(ref_mod(x, y, m));
        @(posedge clock); #1;
        b256.in_valid = 1'b0;
        n = 0;
        while (!b256.out_valid && n < 300) begin @(posedge clock); #1; n++; end
        check("latency256", n, 256);
        @(posedge clock); #1;
    endtask

    // Global time bound so the run always terminates.
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        logic [255:0] rx, ry, rm;

        tbl[0] = '{x: 8'd7,   y: 8'd9,   m: 8'd13,  q: 8'd11};
        tbl[1] = '{x: 8'd200, y: 8'd100, m: 8'd251, q: 8'd171};
        tbl[2] = '{x: 8'd0,   y: 8'd100, m: 8'd251, q: 8'd0};
        tbl[3] = '{x: 8'd12,  y: 8'd12,  m: 8'd13,  q: 8'd1};
        tbl[4] = '{x: 8'd254, y: 8'd254, m: 8'd255, q: 8'd1};
        tbl[5] = '{x: 8'd0,   y: 8'd0,   m: 8'd1,   q: 8'd0};
        tbl[6] = '{x: 8'd199, y: 8'd1,   m: 8'd200, q: 8'd199};
        tbl[7] = '{x: 8'd1,   y: 8'd1,   m: 8'd2,   q: 8'd1};

        reset = 1'b1;
        b8.in_valid = 0;   b8.X = '0;   b8.Y = '0;   b8.M = '0;   b8.out_ready = 0;
        b16.in_valid = 0;  b16.X = '0;  b16.Y = '0;  b16.M = '0;  b16.out_ready = 0;
        b256.in_valid = 0; b256.X = '0; b256.Y = '0; b256.M = '0; b256.out_ready = 0;

        repeat (3) @(posedge clock);
        #1;
        check("rst_vld8",   b8.out_valid, 0);
        check("rst_q8",     {248'b0, b8.Q}, 0);
        check("rst_vld16",  b16.out_valid, 0);
        check("rst_q16",    {240'b0, b16.Q}, 0);
        check("rst_vld256", b256.out_valid, 0);
        check("rst_q256",   b256.Q, 0);
        reset = 1'b0;
        b8.out_ready = 1; b16.out_ready = 1; b256.out_ready = 1;
        @(posedge clock); #1;
        check("rdy_after_rst8",  b8.in_ready, 1);
        check("rdy_after_rst16", b16.in_ready, 1);

        // Table-driven single operations.
        for (int i = 0; i < 8; i++) run8(tbl[i].x, tbl[i].y, tbl[i].m, tbl[i].q);

        // Back-to-back: in_valid stays high, so the second set is taken on the first result's handshake edge.
        b8.X = 8'd7; b8.Y = 8'd9; b8.M = 8'd13; b8.in_valid = 1'b1;
        q8.push_back(8'd11);
        @(posedge clock); #1;
        b8.X = 8'd200; b8.Y = 8'd100; b8.M = 8'd251;
        q8.push_back(8'd171);
        n = 0;
        while (!b8.out_valid && n < 40) begin @(posedge clock); #1; n++; end
        check("b2b_lat1", n, 8);
        @(posedge clock); #1;
        b8.in_valid = 1'b0;
        check("b2b_vld_drop", b8.out_valid, 0);
        n = 1;
        while (!b8.out_valid && n < 40) begin @(posedge clock); #1; n++; end
        check("b2b_gap", n, 9);
        @(posedge clock); #1;

        // Stall with out_ready low: the result is held and operand pulses are ignored.
        b16.out_ready = 1'b0;
        b16.X = 16'd65520; b16.Y = 16'd65520; b16.M = 16'd65521; b16.in_valid = 1'b1;
        q16.push_back(16'd1);
        @(posedge clock); #1;
        b16.in_valid = 1'b0;
        n = 0;
        while (!b16.out_valid && n < 60) begin @(posedge clock); #1; n++; end
        check("latency16", n, 16);
        for (int k = 0; k < 5; k++) begin
            b16.in_valid = k[0];
            b16.X = 16'd5; b16.Y = 16'd5; b16.M = 16'd7;
            check("stall_vld16", b16.out_valid, 1);
            check("stall_q16",   {240'b0, b16.Q}, 1);
            check("stall_rdy16", b16.in_ready, 0);
            @(posedge clock); #1;
        end
        b16.in_valid = 1'b0;
        check("stall_end_vld16", b16.out_valid, 1);
        b16.out_ready = 1'b1;
        @(posedge clock); #1;
        check("post_hs_vld16", b16.out_valid, 0);
        check("post_hs_rdy16", b16.in_ready, 1);
        check("post_hs_q16",   {240'b0, b16.Q}, 1);
        repeat (20) @(posedge clock);
        #1;
        check("no_ghost16", b16.out_valid, 0);

        // Asynchronous reset in the middle of CALC.
        check("pre_rst_q8", {248'b0, b8.Q}, 171);
        b8.X = 8'd200; b8.Y = 8'd100; b8.M = 8'd251; b8.in_valid = 1'b1;
        @(posedge clock); #1;
        b8.in_valid = 1'b0;
        check("calc_rdy8", b8.in_ready, 0);
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_vld8", b8.out_valid, 0);
        check("async_rst_q8",   {248'b0, b8.Q}, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        check("rel_rdy8", b8.in_ready, 1);
        repeat (12) @(posedge clock);
        #1;
        check("no_stale8", b8.out_valid, 0);
        run8(8'd7, 8'd9, 8'd13, 8'd11);

`ifdef MODMUL_RANGE_CHECK_EN
        // X == M violates the range precondition: the result is forced to zero and err is raised.
        b8.X = 8'd13; b8.Y = 8'd9; b8.M = 8'd13; b8.in_valid = 1'b1;
        q8.push_back(8'd0);
        @(posedge clock); #1;
        b8.in_valid = 1'b0;
        n = 0;
        while (!b8.out_valid && n < 40) begin @(posedge clock); #1; n++; end
        check("rc_latency8", n, 8);
        check("rc_err8", b8.err, 1);
        @(posedge clock); #1;
        check("rc_err_clr8", b8.err, 0);
        run8(8'd7, 8'd9, 8'd13, 8'd11);
`endif

        // 256-bit operations against the reference model, starting with the all-ones modulus corner.
        for (int i = 0; i < 40; i++) begin
            if (i == 0) begin
                rm = '1;
                rx = rm - 1'b1;
                ry = rm - 1'b1;
            end else begin
                rm = rand256();
                rm[0] = 1'b1;
                rx = rand256() % rm;
                ry = rand256() % rm;
            end
            run256(rx, ry, rm);
        end

        repeat (4) @(posedge clock);
        #1;
        check("drain8",   q8.size(), 0);
        check("drain16",  q16.size(), 0);
        check("drain256", q256.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
